// File: rtl/spi_rx_framer_if.sv
// Bus bundle between the SPI receive framer and its neighbours: the serial
// RX lines coming in and the Cypress-writer read-side signals.
//
// Handshake: msg_start and rd_req are single-cycle request pulses with no
// ready return. A pulse is acted on only in the state that accepts it
// (msg_start in READY, rd_req in DRAIN); otherwise it is ignored. fifo_q is
// registered and valid from the cycle after an accepted rd_req until the
// next accepted read. got_full_msg/msg_len act as the "message valid" pair.
// dbg_state encodes the framer state: 0 IDLE, 1 RECV, 2 READY, 3 DRAIN.
interface spi_rx_framer_if;
  logic        rx_clk;
  logic        rx_data;
  logic        rx_load;
  logic        rx_stop;
  logic        msg_start;
  logic        rd_req;
  logic [15:0] fifo_q;
  logic        got_full_msg;
  logic [7:0]  msg_len;
  logic        overflow;
  logic [1:0]  dbg_state;

  modport master (
    output rx_clk, rx_data, rx_load, rx_stop, msg_start, rd_req,
    input  fifo_q, got_full_msg, msg_len, overflow, dbg_state
  );

  modport slave (
    input  rx_clk, rx_data, rx_load, rx_stop, msg_start, rd_req,
    output fifo_q, got_full_msg, msg_len, overflow, dbg_state
  );
endinterface

// File: rtl/spi_rx_framer.sv
// Receive-side SPI framer: oversamples the async RX lines, packs bits MSB
// first into 16-bit words, buffers one complete message and hands it to the
// Cypress writer word by word. rst_n is asynchronous and active low.
module spi_rx_framer #(
  parameter int MAX_WORDS   = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_rx_framer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    READY = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Bit positions inside the bundled synchronizer word.
  localparam int B_CLK  = 0;
  localparam int B_DATA = 1;
  localparam int B_LOAD = 2;
  localparam int B_STOP = 3;

  logic [3:0]  sync_q [SYNC_STAGES];
  logic [3:0]  prev_q;
  logic [3:0]  cur_q;

  state_t      state;
  logic [14:0] sr;
  logic [3:0]  bitcnt;
  logic        wr_pend;
  logic [15:0] wr_word;
  logic [7:0]  wr_ptr;
  logic [7:0]  rd_ptr;
  logic [7:0]  wcnt;
  logic        close_pend;
  logic [15:0] fifo_q_r;
  logic        got_full_r;
  logic [7:0]  msg_len_r;
  logic        overflow_r;

  logic [15:0] mem [MAX_WORDS];

  logic        bit_acc;
  logic        bit_data;
  logic        bit_last;
  logic        load_fall;
  logic        stop_rise;
  logic        wr_room;
  logic [7:0]  close_len;

  // Synchronize all four RX lines and keep one extra sample for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'd0;
      prev_q <= 4'd0;
    end else begin
      sync_q[0] <= {bus.rx_stop, bus.rx_load, bus.rx_data, bus.rx_clk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cur_q     = sync_q[SYNC_STAGES-1];
  assign bit_acc   = cur_q[B_CLK] & ~prev_q[B_CLK] & cur_q[B_LOAD];
  assign bit_data  = cur_q[B_DATA];
  assign bit_last  = bit_acc && (bitcnt == 4'd15);
  assign load_fall = prev_q[B_LOAD] & ~cur_q[B_LOAD];
  assign stop_rise = cur_q[B_STOP] & ~prev_q[B_STOP];
  assign wr_room   = (wcnt < 8'(MAX_WORDS));
  // Length seen at close time includes a word being written this same cycle.
  assign close_len = wcnt + {7'd0, wr_pend & wr_room};

  // Message buffer; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_pend && wr_room) mem[wr_ptr] <= wr_word;
  end

  // Framer state machine: bit packing, message close, drain and overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= 15'd0;
      bitcnt     <= 4'd0;
      wr_pend    <= 1'b0;
      wr_word    <= 16'd0;
      wr_ptr     <= 8'd0;
      rd_ptr     <= 8'd0;
      wcnt       <= 8'd0;
      close_pend <= 1'b0;
      fifo_q_r   <= 16'd0;
      got_full_r <= 1'b0;
      msg_len_r  <= 8'd0;
      overflow_r <= 1'b0;
    end else begin
      // A completed word lands in the buffer one cycle after its 16th bit.
      if (wr_pend) begin
        wr_pend <= 1'b0;
        if (wr_room) begin
          wr_ptr <= wr_ptr + 8'd1;
          wcnt   <= wcnt + 8'd1;
        end else begin
          overflow_r <= 1'b1;
        end
      end

      case (state)
        IDLE, RECV: begin
          if (bit_acc) begin
            sr    <= {sr[13:0], bit_data};
            state <= RECV;
            if (bit_last) begin
              wr_word <= {sr, bit_data};
              wr_pend <= 1'b1;
              bitcnt  <= 4'd0;
            end else begin
              bitcnt <= bitcnt + 4'd1;
            end
          end else if (load_fall && bitcnt != 4'd0) begin
            bitcnt     <= 4'd0;
            overflow_r <= 1'b1;
          end

          if (state == RECV && (stop_rise || close_pend)) begin
            if (bit_last) begin
              // Let the coincident word reach the buffer, then close.
              close_pend <= 1'b1;
            end else begin
              close_pend <= 1'b0;
              if (bit_acc || bitcnt != 4'd0) begin
                bitcnt     <= 4'd0;
                overflow_r <= 1'b1;
              end
              if (close_len != 8'd0) begin
                msg_len_r  <= close_len;
                got_full_r <= 1'b1;
                state      <= READY;
              end else begin
                state <= IDLE;
              end
            end
          end
        end

        READY: begin
          if (bit_acc) overflow_r <= 1'b1;
          if (bus.msg_start) begin
            got_full_r <= 1'b0;
            state      <= DRAIN;
          end
        end

        DRAIN: begin
          if (bit_acc) overflow_r <= 1'b1;
          if (bus.rd_req && rd_ptr < msg_len_r) begin
            fifo_q_r <= mem[rd_ptr];
            if (rd_ptr == msg_len_r - 8'd1) begin
              state     <= IDLE;
              rd_ptr    <= 8'd0;
              wr_ptr    <= 8'd0;
              wcnt      <= 8'd0;
              msg_len_r <= 8'd0;
            end else begin
              rd_ptr <= rd_ptr + 8'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fifo_q       = fifo_q_r;
  assign bus.got_full_msg = got_full_r;
  assign bus.msg_len      = msg_len_r;
  assign bus.overflow     = overflow_r;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_spi_rx_framer.sv
// Bench for spi_rx_framer: serial stimulus with random words, a message-level
// reference model (queue of words per message) and a read-data scoreboard.
module tb_spi_rx_framer;
  localparam int MAX_WORDS = 255;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READY = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Clock generation.
  always #5 clk = ~clk;

  spi_rx_framer_if ifc();

  spi_rx_framer #(.MAX_WORDS(MAX_WORDS), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];   // expected fifo_q after each rd_req pulse
  logic [15:0] msg_q[$];   // model: words of the message being built
  logic        exp_ovf;
  logic [15:0] exp_last;   // model: value fifo_q should currently hold

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every rd_req the DUT samples gets its fifo_q compared a half cycle later.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && ifc.rd_req) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fifo_q: read with no expected value, got 0x%0h", ifc.fifo_q);
        end else begin
          check("fifo_q", {16'd0, ifc.fifo_q}, {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.rx_clk = 0; ifc.rx_data = 0; ifc.rx_load = 0; ifc.rx_stop = 0;
    ifc.msg_start = 0; ifc.rd_req = 0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    msg_q.delete();
    exp_ovf  = 1'b0;
    exp_last = 16'd0;
  endtask

  // One serial bit: data set while rx_clk low, then a rising edge.
  task automatic send_bit(input logic b, input logic with_stop);
    ifc.rx_data = b;
    tick(3);
    ifc.rx_clk = 1'b1;
    if (with_stop) ifc.rx_stop = 1'b1;
    tick(3);
    ifc.rx_clk = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic stop_on_last);
    for (int i = 15; i >= 0; i--) send_bit(w[i], stop_on_last && i == 0);
  endtask

  // Model: a complete word joins the message unless the length limit is reached.
  task automatic model_word(input logic [15:0] w);
    if (msg_q.size() < MAX_WORDS) msg_q.push_back(w);
    else exp_ovf = 1'b1;
  endtask

  task automatic send_stop();
    ifc.rx_stop = 1'b1;
    tick(3);
    ifc.rx_stop = 1'b0;
    tick(3);
  endtask

  task automatic check_closed(input string tag);
    int n;
    n = 0;
    while (n < 20 && ifc.got_full_msg !== 1'b1) begin
      tick(1);
      n++;
    end
    check({tag, "_got_full"}, {31'd0, ifc.got_full_msg}, 32'd1);
    check({tag, "_msg_len"}, {24'd0, ifc.msg_len}, msg_q.size());
    check({tag, "_overflow"}, {31'd0, ifc.overflow}, {31'd0, exp_ovf});
    check({tag, "_state_ready"}, {30'd0, ifc.dbg_state}, {30'd0, S_READY});
  endtask

  task automatic pulse_rd(input logic valid, input logic [15:0] w);
    if (valid) exp_last = w;
    exp_q.push_back(exp_last);
    ifc.rd_req = 1'b1;
    tick(1);
    ifc.rd_req = 1'b0;
    tick(1);
  endtask

  task automatic drain(input string tag, input logic rd_with_start);
    ifc.msg_start = 1'b1;
    if (rd_with_start) begin
      ifc.rd_req = 1'b1;
      exp_q.push_back(exp_last);
    end
    tick(1);
    ifc.msg_start = 1'b0;
    ifc.rd_req = 1'b0;
    tick(1);
    check({tag, "_got_drop"}, {31'd0, ifc.got_full_msg}, 32'd0);
    check({tag, "_state_drain"}, {30'd0, ifc.dbg_state}, {30'd0, S_DRAIN});
    foreach (msg_q[i]) pulse_rd(1'b1, msg_q[i]);
    check({tag, "_state_idle"}, {30'd0, ifc.dbg_state}, {30'd0, S_IDLE});
    check({tag, "_len_clear"}, {24'd0, ifc.msg_len}, 32'd0);
    check({tag, "_overflow_end"}, {31'd0, ifc.overflow}, {31'd0, exp_ovf});
    pulse_rd(1'b0, 16'd0);  // read beyond the message: fifo_q must hold
    msg_q.delete();
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus and directed checks.
  initial begin
    logic [15:0] w;
    int len;
    do_reset();
    check("reset_fifo_q", {16'd0, ifc.fifo_q}, 32'd0);
    check("reset_got_full", {31'd0, ifc.got_full_msg}, 32'd0);
    check("reset_msg_len", {24'd0, ifc.msg_len}, 32'd0);
    check("reset_overflow", {31'd0, ifc.overflow}, 32'd0);
    check("reset_state", {30'd0, ifc.dbg_state}, {30'd0, S_IDLE});

    // Three known words, MSG_START coincident with a read that must be ignored.
    ifc.rx_load = 1'b1; tick(3);
    send_word(16'h1234, 1'b0); model_word(16'h1234);
    send_word(16'hABCD, 1'b0); model_word(16'hABCD);
    send_word(16'h00FF, 1'b0); model_word(16'h00FF);
    ifc.rx_load = 1'b0; tick(3);
    send_stop();
    check_closed("t1");
    drain("t1", 1'b1);

    // STOP with nothing sent, then a read in IDLE.
    send_stop();
    tick(4);
    check("t4_got_full", {31'd0, ifc.got_full_msg}, 32'd0);
    check("t4_state", {30'd0, ifc.dbg_state}, {30'd0, S_IDLE});
    pulse_rd(1'b0, 16'd0);

    // 16th bit together with STOP, then bits arriving while READY.
    do_reset();
    ifc.rx_load = 1'b1; tick(3);
    w = 16'($urandom); send_word(w, 1'b0); model_word(w);
    w = 16'($urandom); send_word(w, 1'b1); model_word(w);
    tick(3); ifc.rx_stop = 1'b0; tick(3);
    check_closed("t5");
    send_word(16'($urandom), 1'b0);
    exp_ovf = 1'b1;
    ifc.rx_load = 1'b0; tick(6);
    check("t5_ready_ovf", {31'd0, ifc.overflow}, 32'd1);
    check("t5_len_kept", {24'd0, ifc.msg_len}, msg_q.size());
    drain("t5", 1'b0);

    // 20 bits: one whole word plus a partial one discarded by LOAD falling.
    do_reset();
    ifc.rx_load = 1'b1; tick(3);
    w = 16'($urandom); send_word(w, 1'b0); model_word(w);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
    ifc.rx_load = 1'b0; tick(3);
    exp_ovf = 1'b1;
    send_stop();
    check_closed("t2");
    drain("t2", 1'b0);

    // Random messages, no overflow expected.
    do_reset();
    for (int m = 0; m < 3; m++) begin
      len = $urandom_range(1, 6);
      ifc.rx_load = 1'b1; tick(3);
      for (int k = 0; k < len; k++) begin
        w = 16'($urandom); send_word(w, 1'b0); model_word(w);
      end
      ifc.rx_load = 1'b0; tick(3);
      send_stop();
      check_closed("rnd");
      drain("rnd", 1'b0);
    end

    // Length limit: 256 words, the last one dropped.
    do_reset();
    ifc.rx_load = 1'b1; tick(3);
    for (int k = 0; k < 256; k++) begin
      w = 16'($urandom); send_word(w, 1'b0); model_word(w);
    end
    ifc.rx_load = 1'b0; tick(3);
    send_stop();
    check("t3_len_255", {24'd0, ifc.msg_len}, 32'd255);
    check_closed("t3");
    drain("t3", 1'b0);

    // Reset in the middle of a drain, then a fresh one-word message.
    do_reset();
    ifc.rx_load = 1'b1; tick(3);
    for (int k = 0; k < 4; k++) begin
      w = 16'($urandom); send_word(w, 1'b0); model_word(w);
    end
    ifc.rx_load = 1'b0; tick(3);
    send_stop();
    check_closed("t6");
    ifc.msg_start = 1'b1; tick(1); ifc.msg_start = 1'b0; tick(1);
    pulse_rd(1'b1, msg_q[0]);
    pulse_rd(1'b1, msg_q[1]);
    rst_n = 1'b0;
    #1;
    check("t6_rst_fifo_q", {16'd0, ifc.fifo_q}, 32'd0);
    check("t6_rst_got_full", {31'd0, ifc.got_full_msg}, 32'd0);
    check("t6_rst_msg_len", {24'd0, ifc.msg_len}, 32'd0);
    check("t6_rst_state", {30'd0, ifc.dbg_state}, {30'd0, S_IDLE});
    tick(1);
    do_reset();
    ifc.rx_load = 1'b1; tick(3);
    w = 16'($urandom); send_word(w, 1'b0); model_word(w);
    ifc.rx_load = 1'b0; tick(3);
    send_stop();
    check_closed("t6b");
    drain("t6b", 1'b0);

    tick(4);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
